sram_ctrl: RTL and testbench

SRAM_CTRL -- requirements
Module: sram_ctrl

---
 rtl/sram_ctrl.sv | 170 +++++++++++++++++
 tb/tb_sram_ctrl.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_ctrl.sv
// Asynchronous-SRAM controller for a 16-bit CPU bus driving two 16-bit SRAM chips.
// The strobes, byte enables and data-enable are registered from the next state so the pins stay glitch-free.
module sram_ctrl #(
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        fpga_clk,
    input  logic        reset,
    input  logic        bus_as,
    input  logic [18:0] bus_addr,
    input  logic        bus_uds,
    input  logic        bus_lds,
    input  logic        bus_rw,
    input  logic [15:0] bus_wdata,
    output logic [15:0] bus_rdata,
    output logic        bus_dtack,
    output logic [17:0] ram_addr,
    output logic [31:0] ram_data_o,
    input  logic [31:0] ram_data_i,
    output logic        ram_data_oe,
    output logic [1:0]  ram_ce_n,
    output logic [1:0]  ram_ub_n,
    output logic [1:0]  ram_lb_n,
    output logic        ram_we_n,
    output logic        ram_oe_n
);

    typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, ACK} state_t;

    localparam logic [3:0] CNT_LAST = 4'(WAIT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        chip_q, chip_d;
    logic [17:0] addr_q, addr_d;
    logic        rw_q, rw_d;
    logic        uds_q, uds_d;
    logic        lds_q, lds_d;
    logic [15:0] wdata_q, wdata_d;
    logic [15:0] rdata_q, rdata_d;
    logic        dtack_q, dtack_d;
    logic        data_oe_q, data_oe_d;
    logic [1:0]  ce_n_q, ce_n_d;
    logic [1:0]  ub_n_q, ub_n_d;
    logic [1:0]  lb_n_q, lb_n_d;
    logic        we_n_q, we_n_d;
    logic        oe_n_q, oe_n_d;
    logic        in_access;
    logic [1:0]  chip_sel_n;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        chip_d    = chip_q;
        addr_d    = addr_q;
        rw_d      = rw_q;
        uds_d     = uds_q;
        lds_d     = lds_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        dtack_d   = dtack_q;

        case (state_q)
            IDLE: begin
                dtack_d = 1'b0;
                if (bus_as && (bus_uds || bus_lds)) begin
                    chip_d  = bus_addr[18];
                    addr_d  = bus_addr[17:0];
                    rw_d    = bus_rw;
                    uds_d   = bus_uds;
                    lds_d   = bus_lds;
                    wdata_d = bus_wdata;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                cnt_d   = 4'd0;
                state_d = STROBE;
            end
            STROBE: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = 4'd0;
                    state_d = HOLD;
                    if (rw_q) begin
                        rdata_d = chip_q ? ram_data_i[31:16] : ram_data_i[15:0];
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            HOLD: begin
                // An aborted cycle still completes its SRAM timing; it just skips the acknowledge.
                if (bus_as) begin
                    dtack_d = 1'b1;
                    state_d = ACK;
                end else begin
                    state_d = IDLE;
                end
            end
            ACK: begin
                if (!bus_as) begin
                    dtack_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                dtack_d = 1'b0;
                state_d = IDLE;
            end
        endcase

        in_access  = (state_d == SETUP) || (state_d == STROBE) || (state_d == HOLD);
        chip_sel_n = chip_d ? 2'b01 : 2'b10;
        ce_n_d     = in_access ? chip_sel_n : 2'b11;
        ub_n_d     = (in_access && uds_d) ? chip_sel_n : 2'b11;
        lb_n_d     = (in_access && lds_d) ? chip_sel_n : 2'b11;
        oe_n_d     = !((state_d == STROBE) && rw_d);
        we_n_d     = !((state_d == STROBE) && !rw_d);
        data_oe_d  = in_access && !rw_d;
    end

    always_ff @(posedge fpga_clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            chip_q    <= 1'b0;
            addr_q    <= 18'd0;
            rw_q      <= 1'b1;
            uds_q     <= 1'b0;
            lds_q     <= 1'b0;
            wdata_q   <= 16'd0;
            rdata_q   <= 16'd0;
            dtack_q   <= 1'b0;
            data_oe_q <= 1'b0;
            ce_n_q    <= 2'b11;
            ub_n_q    <= 2'b11;
            lb_n_q    <= 2'b11;
            we_n_q    <= 1'b1;
            oe_n_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            chip_q    <= chip_d;
            addr_q    <= addr_d;
            rw_q      <= rw_d;
            uds_q     <= uds_d;
            lds_q     <= lds_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            dtack_q   <= dtack_d;
            data_oe_q <= data_oe_d;
            ce_n_q    <= ce_n_d;
            ub_n_q    <= ub_n_d;
            lb_n_q    <= lb_n_d;
            we_n_q    <= we_n_d;
            oe_n_q    <= oe_n_d;
        end
    end

    assign bus_rdata   = rdata_q;
    assign bus_dtack   = dtack_q;
    assign ram_addr    = addr_q;
    assign ram_data_o  = {wdata_q, wdata_q};
    assign ram_data_oe = data_oe_q;
    assign ram_ce_n    = ce_n_q;
    assign ram_ub_n    = ub_n_q;
    assign ram_lb_n    = lb_n_q;
    assign ram_we_n    = we_n_q;
    assign ram_oe_n    = oe_n_q;

endmodule

// File: tb/tb_sram_ctrl.sv
// Bench for sram_ctrl: table of accesses on a WAIT_CYCLES=2 instance, hand sequences for abort/reset,
// and a long-hold read on a WAIT_CYCLES=5 instance; read data goes through a scoreboard queue.
module tb_sram_ctrl;

    logic        fpga_clk = 1'b0;
    logic        reset = 1'b1;
    logic        bus_as = 1'b0;
    logic [18:0] bus_addr = '0;
    logic        bus_uds = 1'b0;
    logic        bus_lds = 1'b0;
    logic        bus_rw = 1'b1;
    logic [15:0] bus_wdata = '0;
    logic [31:0] ram_data_i = '0;

    logic [15:0] rdata2, rdata5;
    logic        dtack2, dtack5;
    logic [17:0] addr2, addr5;
    logic [31:0] dout2, dout5;
    logic        doe2, doe5;
    logic [1:0]  ce2, ce5, ub2, ub5, lb2, lb5;
    logic        we2, we5, oe2, oe5;

    logic        sel5 = 1'b0;
    logic [15:0] o_rdata;
    logic        o_dtack, o_doe, o_we, o_oe;
    logic [17:0] o_addr;
    logic [31:0] o_dout;
    logic [1:0]  o_ce, o_ub, o_lb;

    int total = 0;
    int bad = 0;
    logic [15:0] sb_q[$];

    always #5 fpga_clk = ~fpga_clk;

    sram_ctrl #(.WAIT_CYCLES(2)) dut2 (
        .fpga_clk(fpga_clk), .reset(reset), .bus_as(bus_as), .bus_addr(bus_addr),
        .bus_uds(bus_uds), .bus_lds(bus_lds), .bus_rw(bus_rw), .bus_wdata(bus_wdata),
        .bus_rdata(rdata2), .bus_dtack(dtack2), .ram_addr(addr2), .ram_data_o(dout2),
        .ram_data_i(ram_data_i), .ram_data_oe(doe2), .ram_ce_n(ce2), .ram_ub_n(ub2),
        .ram_lb_n(lb2), .ram_we_n(we2), .ram_oe_n(oe2)
    );

    sram_ctrl #(.WAIT_CYCLES(5)) dut5 (
        .fpga_clk(fpga_clk), .reset(reset), .bus_as(bus_as), .bus_addr(bus_addr),
        .bus_uds(bus_uds), .bus_lds(bus_lds), .bus_rw(bus_rw), .bus_wdata(bus_wdata),
        .bus_rdata(rdata5), .bus_dtack(dtack5), .ram_addr(addr5), .ram_data_o(dout5),
        .ram_data_i(ram_data_i), .ram_data_oe(doe5), .ram_ce_n(ce5), .ram_ub_n(ub5),
        .ram_lb_n(lb5), .ram_we_n(we5), .ram_oe_n(oe5)
    );

    always_comb begin
        o_rdata = sel5 ? rdata5 : rdata2;
        o_dtack = sel5 ? dtack5 : dtack2;
        o_addr  = sel5 ? addr5  : addr2;
        o_dout  = sel5 ? dout5  : dout2;
        o_doe   = sel5 ? doe5   : doe2;
        o_ce    = sel5 ? ce5    : ce2;
        o_ub    = sel5 ? ub5    : ub2;
        o_lb    = sel5 ? lb5    : lb2;
        o_we    = sel5 ? we5    : we2;
        o_oe    = sel5 ? oe5    : oe2;
    end

    typedef struct {
        logic [18:0] addr;
        logic        uds;
        logic        lds;
        logic        rw;
        logic [15:0] wdata;
        logic [31:0] rdin;
        logic [17:0] e_addr;
        logic [1:0]  e_ce;
        logic [1:0]  e_ub;
        logic [1:0]  e_lb;
        logic [31:0] e_dout;
        logic [15:0] e_rdata;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge fpga_clk);
        #1;
    endtask

    // Strobe-exclusion rules on both instances, every cycle.
    always @(negedge fpga_clk) begin
        chk("inv2_oe_doe", 32'(!oe2 && doe2), 0);
        chk("inv2_we_oe",  32'(!we2 && !oe2), 0);
        chk("inv5_oe_doe", 32'(!oe5 && doe5), 0);
        chk("inv5_we_oe",  32'(!we5 && !oe5), 0);
    end

    task automatic chk_idle(input string name);
        chk({name, "_ce"}, 32'(o_ce), 2'b11);
        chk({name, "_ub"}, 32'(o_ub), 2'b11);
        chk({name, "_lb"}, 32'(o_lb), 2'b11);
        chk({name, "_we"}, 32'(o_we), 1);
        chk({name, "_oe"}, 32'(o_oe), 1);
        chk({name, "_doe"}, 32'(o_doe), 0);
    endtask

    task automatic drive(input vec_t v);
        bus_addr   = v.addr;
        bus_uds    = v.uds;
        bus_lds    = v.lds;
        bus_rw     = v.rw;
        bus_wdata  = v.wdata;
        ram_data_i = v.rdin;
        bus_as     = 1'b1;
    endtask

    // Edge k counts from the edge that samples the request (k=1): SETUP, STROBE x w, HOLD, then dtack.
    task automatic access(input vec_t v, input int w, input int extra);
        logic [15:0] exp_r;
        drive(v);
        if (v.rw) sb_q.push_back(v.e_rdata);
        for (int k = 1; k <= w + 3; k++) begin
            step();
            if (k <= w + 2) begin
                chk("dtack_early", 32'(o_dtack), 0);
                chk("ce_n", 32'(o_ce), 32'(v.e_ce));
                chk("ub_n", 32'(o_ub), 32'(v.e_ub));
                chk("lb_n", 32'(o_lb), 32'(v.e_lb));
                chk("ram_addr", 32'(o_addr), 32'(v.e_addr));
                chk("data_oe", 32'(o_doe), 32'(!v.rw));
                if (!v.rw) chk("data_o", o_dout, v.e_dout);
                if (k >= 2 && k <= w + 1) begin
                    chk("strobe_oe", 32'(o_oe), 32'(!v.rw));
                    chk("strobe_we", 32'(o_we), 32'(v.rw));
                end else begin
                    chk("edge_oe", 32'(o_oe), 1);
                    chk("edge_we", 32'(o_we), 1);
                end
            end else begin
                chk("dtack_rise", 32'(o_dtack), 1);
                chk_idle("ack");
                if (v.rw) begin
                    if (sb_q.size() == 0) begin
                        chk("sb_empty", 1, 0);
                    end else begin
                        exp_r = sb_q.pop_front();
                        chk("rdata", 32'(o_rdata), 32'(exp_r));
                    end
                end
            end
        end
        for (int i = 0; i < extra; i++) begin
            step();
            chk("dtack_hold", 32'(o_dtack), 1);
        end
        bus_as = 1'b0;
        step();
        chk("dtack_fall", 32'(o_dtack), 0);
        chk_idle("after");
        $display("access addr=%h rw=%0d uds=%0d lds=%0d w=%0d done", v.addr, v.rw, v.uds, v.lds, w);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{19'h00010, 1'b1, 1'b1, 1'b0, 16'hBEEF, 32'h0000_0000,
                    18'h00010, 2'b10, 2'b10, 2'b10, 32'hBEEF_BEEF, 16'h0000};
        vecs[1] = '{19'h40010, 1'b1, 1'b0, 1'b1, 16'h0000, 32'h12AB_5555,
                    18'h00010, 2'b01, 2'b01, 2'b11, 32'h0000_0000, 16'h12AB};
        vecs[2] = '{19'h00123, 1'b0, 1'b1, 1'b1, 16'h0000, 32'h9999_3C4D,
                    18'h00123, 2'b10, 2'b11, 2'b10, 32'h0000_0000, 16'h3C4D};
        vecs[3] = '{19'h7FFFF, 1'b1, 1'b1, 1'b0, 16'h0001, 32'h0000_0000,
                    18'h3FFFF, 2'b01, 2'b01, 2'b01, 32'h0001_0001, 16'h0000};
        vecs[4] = '{19'h40000, 1'b1, 1'b1, 1'b1, 16'h0000, 32'hA5A5_0F0F,
                    18'h00000, 2'b01, 2'b01, 2'b01, 32'h0000_0000, 16'hA5A5};

        step();
        step();
        chk("rst_dtack", 32'(o_dtack), 0);
        chk("rst_rdata", 32'(o_rdata), 0);
        chk("rst_addr", 32'(o_addr), 0);
        chk("rst_dout", o_dout, 0);
        chk_idle("rst");
        reset = 1'b0;
        step();

        for (int i = 0; i < 5; i++) begin
            access(vecs[i], 2, 0);
        end

        // Address strobe with no byte strobes must not start an access.
        bus_addr = 19'h00055;
        bus_uds  = 1'b0;
        bus_lds  = 1'b0;
        bus_as   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("nostrobe_dtack", 32'(o_dtack), 0);
            chk_idle("nostrobe");
        end
        bus_as = 1'b0;
        step();
        $display("no-strobe request ignored");

        // Abort: bus_as dropped during STROBE; the write pulse still runs full length.
        drive(vecs[0]);
        step();
        step();
        chk("abort_we_s1", 32'(o_we), 0);
        bus_as = 1'b0;
        step();
        chk("abort_we_s2", 32'(o_we), 0);
        step();
        chk("abort_we_hold", 32'(o_we), 1);
        chk("abort_ce_hold", 32'(o_ce), 2'b10);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("abort_dtack", 32'(o_dtack), 0);
            chk_idle("abort_idle");
        end
        $display("aborted write done");

        // Reset in the middle of a write strobe.
        drive(vecs[3]);
        step();
        step();
        chk("rstmid_we_before", 32'(o_we), 0);
        reset  = 1'b1;
        bus_as = 1'b0;
        step();
        chk("rstmid_dtack", 32'(o_dtack), 0);
        chk("rstmid_addr", 32'(o_addr), 0);
        chk("rstmid_dout", o_dout, 0);
        chk_idle("rstmid");
        reset = 1'b0;
        step();
        access(vecs[1], 2, 0);
        $display("reset mid-write then read done");

        // Long wait states and a bus_as held past dtack on the WAIT_CYCLES=5 instance.
        for (int i = 0; i < 10; i++) step();
        sel5 = 1'b1;
        #1;
        chk_idle("w5_pre");
        access(vecs[4], 5, 3);
        access(vecs[0], 5, 0);
        sel5 = 1'b0;

        for (int i = 0; i < 3; i++) step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
